img_loader: RTL and testbench
=============================

# img_loader

Upstream image-fill stage for the VGA picture display. Receives a byte stream from a UART receiver, frames it with a two-byte sync header, and assembles RGB565 pixels high-byte-first. Writes the pixels sequentially into the 200×200 image block RAM that the VGA scan stage reads, so a new picture can be loaded without re-synthesising the memory init file.

## Interface

**Parameters**
- `PIXELS`, default 40000: pixels per frame (200×200); must be ≤ 65536.
- `TIMEOUT_CYC`, default 1000000: idle-gap limit in clock cycles; only used with `IMG_LOADER_TIMEOUT_EN`.

**Ports**
- `clk` input 1: single clock for all logic; the VGA pixel clock domain, same as the RAM write port.
- `rst` input 1: reset, asynchronous, active-high.
- `rx_data` input 8: received byte.
- `rx_valid` input 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `we` output 1: RAM write enable, one-cycle pulse per pixel.
- `waddr` output 16: RAM write address.
- `wdata` output 16: RGB565 pixel, `{R[4:0],G[5:0],B[4:0]}`.
- `busy` output 1: high from a valid header until frame end or abort.
- `frame_done` output 1: one-cycle pulse on the final pixel write.
- `err` output 1: one-cycle pulse on timeout abort; tied 0 without the macro.

## Operation

- States: `IDLE`, `SYNC2`, `HI`, `LO`.
- `IDLE`:
  - `rx_valid` with byte 0xAA → `SYNC2`.
  - Any other byte is ignored.
- `SYNC2`:
  - 0x55 → `HI`, `busy`←1, pixel counter←0.
  - 0xAA → stay in `SYNC2`.
  - Other byte → `IDLE`.
- `HI`: on `rx_valid`, latch the byte as the pixel high byte → `LO`. Byte values are not interpreted; 0xAA/0x55 are pixel data here.
- `LO`: on `rx_valid`:
  - `wdata`←{hi, rx_data}.
  - `waddr`←pixel counter.
  - `we`←1.
  - Counter increments.
  - If counter == `PIXELS-1`: `frame_done`←1, `busy`←0 → `IDLE`. Otherwise → `HI`.
- The pixel counter is 16 bits. It never wraps within a frame because the terminal compare ends the frame first.
- A new header in `IDLE` restarts at address 0. The previous picture is overwritten in place, and no double buffering is done.
- Cycles without `rx_valid` hold state. Outputs other than pulses hold their last value.

## Timing

- Reset values (asynchronous, immediate on `rst` high):
  - State `IDLE`.
  - `we`=0, `waddr`=0, `wdata`=0.
  - `busy`=0, `frame_done`=0, `err`=0.
  - Counters 0.
- Write latency: the `LO`-state `rx_valid` in cycle n gives `we`/`waddr`/`wdata` registered in cycle n+1, high for exactly one cycle.
- `frame_done` is asserted in the same cycle as the final `we`.
- `busy` rises the cycle after the 0x55 strobe. It falls the same cycle `frame_done` is high.
- Back-to-back `rx_valid` every cycle is legal. Maximum write rate is one pixel per two cycles.
- Reset mid-frame: the frame is abandoned and the partial picture stays in RAM. The next frame needs a full header.

## Configuration

- `IMG_LOADER_TIMEOUT_EN` defined:
  - A 24-bit gap counter runs in `HI`/`LO`. It clears on every `rx_valid` and on entering `HI` from `SYNC2`.
  - When it reaches `TIMEOUT_CYC-1` with no strobe, the next cycle produces: → `IDLE`, `busy`←0, `err` one-cycle pulse.
  - On that abort there is no `we` and no `frame_done`, and written pixels remain in RAM.
  - A strobe in the same cycle as the limit is accepted normally, and no abort occurs.
- Macro undefined: no gap counter; a stalled frame waits indefinitely; `err` constant 0.

## Test plan

- Reset, then bytes AA 55 followed by 40000 pixel pairs F8 00 (red) → 40000 `we` pulses:
  - `waddr` 0..39999 in order, `wdata`=0xF800 each.
  - `frame_done` with `waddr`=39999.
  - `busy` low afterwards.
- Header sequences AA AA 55, then 12 34 → `wdata`=0x1234 at `waddr`=0. Separately, AA 13 55 12 34 → no `we`, stays `IDLE`.
- Pixel bytes AA 55 within a frame (pixel 0 = AA 55) → written as `wdata`=0xAA55 at address 0, no resync.
- Two frames back-to-back (second frame data 07 E0) → second frame writes addresses 0..39999 with 0x07E0, two `frame_done` pulses.
- Macro on, `TIMEOUT_CYC`=100: header plus 3 pixels, then silence → `err` pulse 100 cycles after the last strobe, `busy`=0. A following header plus pixel restarts at `waddr`=0.
- `rst` asserted after 10 pixels → all outputs 0 immediately. A fresh frame starts at address 0.

Source files
------------

// File: rtl/img_loader_if.sv
// Byte-in / pixel-write-out bundle between the UART receiver, img_loader and the image RAM.
// The slave side is the loader; the master side feeds bytes and observes the RAM writes.
interface img_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        we;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        busy;
    logic        frame_done;
    logic        err;

    modport slave (
        input  rx_data, rx_valid,
        output we, waddr, wdata, busy, frame_done, err
    );

    modport master (
        output rx_data, rx_valid,
        input  we, waddr, wdata, busy, frame_done, err
    );
endinterface

// File: rtl/img_loader.sv
// Frames a UART byte stream (AA 55 header) into RGB565 pixels written sequentially to image RAM.
// Optional idle-gap abort is enabled by defining IMG_LOADER_TIMEOUT_EN.
module img_loader #(
    parameter int PIXELS      = 40000,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    img_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SYNC2, HI, LO} state_t;

    localparam logic [15:0] LAST_PIX = 16'(PIXELS - 1);

    // Catch parameter values the 16-bit address and 24-bit gap counter cannot represent.
    if (PIXELS < 1 || PIXELS > 65536 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 16777216) begin : g_bad_cfg
        $error("img_loader: PIXELS or TIMEOUT_CYC out of range");
    end

    state_t      r_state;
    logic [7:0]  r_hi;
    logic [15:0] r_cnt;
    logic        r_we;
    logic [15:0] r_waddr;
    logic [15:0] r_wdata;
    logic        r_busy;
    logic        r_done;

`ifdef IMG_LOADER_TIMEOUT_EN
    localparam logic [23:0] GAP_LAST = 24'(TIMEOUT_CYC - 1);
    logic [23:0] r_gap;
    logic        r_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef IMG_LOADER_TIMEOUT_EN
            r_gap   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            if (bus.rx_valid) begin
                case (r_state)
                    IDLE: begin
                        if (bus.rx_data == 8'hAA) r_state <= SYNC2;
                    end
                    SYNC2: begin
                        if (bus.rx_data == 8'h55) begin
                            r_state <= HI;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                        end else if (bus.rx_data != 8'hAA) begin
                            r_state <= IDLE;
                        end
                    end
                    HI: begin
                        r_hi    <= bus.rx_data;
                        r_state <= LO;
                    end
                    LO: begin
                        r_we    <= 1'b1;
                        r_waddr <= r_cnt;
                        r_wdata <= {r_hi, bus.rx_data};
                        r_cnt   <= r_cnt + 16'd1;
                        if (r_cnt == LAST_PIX) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_state <= HI;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
`ifdef IMG_LOADER_TIMEOUT_EN
            // Gap counter only runs mid-frame; a strobe on the limit cycle wins over the abort.
            r_err <= 1'b0;
            if (bus.rx_valid || !(r_state == HI || r_state == LO)) begin
                r_gap <= '0;
            end else if (r_gap == GAP_LAST) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
                r_gap   <= '0;
            end else begin
                r_gap <= r_gap + 24'd1;
            end
`endif
        end
    end

    assign bus.we         = r_we;
    assign bus.waddr      = r_waddr;
    assign bus.wdata      = r_wdata;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;
`ifdef IMG_LOADER_TIMEOUT_EN
    assign bus.err        = r_err;
`else
    assign bus.err        = 1'b0;
`endif
endmodule

// File: tb/tb_img_loader.sv
// Self-checking bench for img_loader: vector table, hand sequences and a random byte stream
// scored against a byte-stream parser model. Timeout checks run when IMG_LOADER_TIMEOUT_EN is defined.
module tb_img_loader;
`ifdef IMG_LOADER_TIMEOUT_EN
    localparam int TOC = 100;
`else
    localparam int TOC = 1000000;
`endif
    localparam int NPIX = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    img_loader_if bus();

    img_loader #(.PIXELS(NPIX), .TIMEOUT_CYC(TOC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        last;
    } wr_t;
    wr_t exp_q[$];

    // Parser model: a header is an 0x55 following an 0xAA while outside a frame.
    bit          m_in_frame;
    bit          m_prev_aa;
    bit          m_have_hi;
    logic [7:0]  m_hi;
    int          m_idx;

    task automatic model_reset();
        m_in_frame = 0;
        m_prev_aa  = 0;
        m_have_hi  = 0;
        m_hi       = 8'h00;
        m_idx      = 0;
        exp_q.delete();
    endtask

    task automatic model_abort();
        m_in_frame = 0;
        m_prev_aa  = 0;
        m_have_hi  = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        wr_t w;
        if (!m_in_frame) begin
            if (m_prev_aa && b == 8'h55) begin
                m_in_frame = 1;
                m_idx      = 0;
                m_have_hi  = 0;
            end
            m_prev_aa = (b == 8'hAA);
        end else if (!m_have_hi) begin
            m_hi      = b;
            m_have_hi = 1;
        end else begin
            w.addr = 16'(m_idx);
            w.data = {m_hi, b};
            w.last = (m_idx == NPIX - 1);
            exp_q.push_back(w);
            m_idx++;
            m_have_hi = 0;
            if (m_idx == NPIX) begin
                m_in_frame = 0;
                m_prev_aa  = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Advance one cycle and score any RAM write seen after the rising edge.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (bus.we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_we: got we=1 waddr=%0h wdata=%0h, expected no write", bus.waddr, bus.wdata);
            end else begin
                e = exp_q.pop_front();
                chk("waddr", 32'(bus.waddr), 32'(e.addr));
                chk("wdata", 32'(bus.wdata), 32'(e.data));
                chk("frame_done_on_we", 32'(bus.frame_done), 32'(e.last));
            end
        end else if (bus.frame_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_without_we: got frame_done=1 we=0, expected frame_done only with we");
        end
        if (bus.frame_done) begin
            n_done++;
            chk("busy_at_done", 32'(bus.busy), 0);
        end
`ifndef IMG_LOADER_TIMEOUT_EN
        if (bus.err !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL err_tied: got %b, expected 0", bus.err);
        end
`endif
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        model_byte(b);
        tick();
        bus.rx_valid = 1'b0;
        $display("byte %02h -> we=%b waddr=%0d wdata=%04h busy=%b done=%b err=%b",
                 b, bus.we, bus.waddr, bus.wdata, bus.busy, bus.frame_done, bus.err);
    endtask

    task automatic hw_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    32'(bus.we),         0);
        chk({tag, "_waddr"}, 32'(bus.waddr),      0);
        chk({tag, "_wdata"}, 32'(bus.wdata),      0);
        chk({tag, "_busy"},  32'(bus.busy),       0);
        chk({tag, "_done"},  32'(bus.frame_done), 0);
        chk({tag, "_err"},   32'(bus.err),        0);
    endtask

    typedef struct {
        bit          v;
        logic [7:0]  d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] data;
        bit          busy;
    } vec_t;
    vec_t tv[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        model_reset();

        // Reset state
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // Vector table: AA AA 55 header, pixel 0x1234, then AA 55 taken as pixel data
        tv[0] = '{1'b1, 8'hAA, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tv[1] = '{1'b1, 8'hAA, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tv[2] = '{1'b1, 8'h55, 1'b0, 16'h0000, 16'h0000, 1'b1};
        tv[3] = '{1'b1, 8'h12, 1'b0, 16'h0000, 16'h0000, 1'b1};
        tv[4] = '{1'b1, 8'h34, 1'b1, 16'h0000, 16'h1234, 1'b1};
        tv[5] = '{1'b0, 8'h00, 1'b0, 16'h0000, 16'h1234, 1'b1};
        tv[6] = '{1'b1, 8'hAA, 1'b0, 16'h0000, 16'h1234, 1'b1};
        tv[7] = '{1'b1, 8'h55, 1'b1, 16'h0001, 16'hAA55, 1'b1};
        tv[8] = '{1'b0, 8'h00, 1'b0, 16'h0001, 16'hAA55, 1'b1};
        for (int i = 0; i < 9; i++) begin
            if (tv[i].v) send(tv[i].d);
            else tick();
            chk($sformatf("vec%0d_we", i),    32'(bus.we),    32'(tv[i].we));
            chk($sformatf("vec%0d_waddr", i), 32'(bus.waddr), 32'(tv[i].addr));
            chk($sformatf("vec%0d_wdata", i), 32'(bus.wdata), 32'(tv[i].data));
            chk($sformatf("vec%0d_busy", i),  32'(bus.busy),  32'(tv[i].busy));
        end

        // Broken header AA 13 55 then bytes: nothing written, never busy
        hw_reset();
        begin
            logic [7:0] bad_hdr [5];
            bad_hdr = '{8'hAA, 8'h13, 8'h55, 8'h12, 8'h34};
            for (int i = 0; i < 5; i++) begin
                send(bad_hdr[i]);
                chk($sformatf("badhdr%0d_we", i),   32'(bus.we),   0);
                chk($sformatf("badhdr%0d_busy", i), 32'(bus.busy), 0);
            end
        end

        // Two back-to-back full frames with bytes every cycle
        hw_reset();
        begin
            int d0;
            d0 = n_done;
            send(8'hAA);
            send(8'h55);
            for (int p = 0; p < NPIX; p++) begin
                send(8'hF8);
                send(8'h00);
            end
            chk("frame1_done_count", 32'(n_done - d0), 1);
            chk("frame1_busy_after", 32'(bus.busy), 0);
            chk("frame1_drained", 32'(exp_q.size()), 0);
            send(8'hAA);
            send(8'h55);
            for (int p = 0; p < NPIX; p++) begin
                send(8'h07);
                send(8'hE0);
            end
            chk("frame2_done_count", 32'(n_done - d0), 2);
            chk("frame2_busy_after", 32'(bus.busy), 0);
            chk("frame2_drained", 32'(exp_q.size()), 0);
        end

        // Asynchronous reset after 10 pixels, then a fresh frame from address 0
        hw_reset();
        send(8'hAA);
        send(8'h55);
        for (int p = 0; p < 10; p++) begin
            send(8'(p + 1));
            send(8'h5A);
        end
        #1 rst = 1'b1;
        #1 chk_all_zero("midreset");
        model_reset();
        tick();
        rst = 1'b0;
        send(8'hAA);
        send(8'h55);
        send(8'hAB);
        send(8'hCD);
        chk("after_reset_waddr", 32'(bus.waddr), 0);
        chk("after_reset_drained", 32'(exp_q.size()), 0);

`ifdef IMG_LOADER_TIMEOUT_EN
        // Silence after 3 pixels: err must pulse TOC cycles after the last strobe
        hw_reset();
        send(8'hAA);
        send(8'h55);
        for (int p = 0; p < 3; p++) begin
            send(8'h12);
            send(8'h34);
        end
        begin
            bit seen;
            seen = 0;
            for (int k = 1; k <= TOC + 5 && !seen; k++) begin
                tick();
                if (bus.err) begin
                    seen = 1;
                    chk("err_delay", 32'(k), 32'(TOC));
                    chk("busy_on_err", 32'(bus.busy), 0);
                end
            end
            if (!seen) begin
                n_cmp++;
                n_bad++;
                $display("FAIL err_missing: got no err pulse, expected one after %0d cycles", TOC);
            end
            tick();
            chk("err_width", 32'(bus.err), 0);
        end
        model_abort();
        send(8'hAA);
        send(8'h55);
        send(8'h0F);
        send(8'h0F);
        chk("after_abort_waddr", 32'(bus.waddr), 0);
        chk("after_abort_drained", 32'(exp_q.size()), 0);
`endif

        // Random byte stream biased toward header bytes
        hw_reset();
        for (int i = 0; i < 800; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            if (r < 3)      b = 8'hAA;
            else if (r < 5) b = 8'h55;
            else            b = 8'($urandom_range(0, 255));
            send(b);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();
        chk("random_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
